// File: rtl/mul_sched_pkg.sv
// Shared constants, id-width helper and tag record for the round-robin
// multiplier scheduler.
package mul_sched_pkg;

   localparam int MUL_LAT  = 2;
   localparam int MAX_ID_W = 4;

   function automatic int id_w(input int nreq);
      return (nreq <= 2) ? 1 : $clog2(nreq);
   endfunction

   // id is sized for the largest supported requester count (16)
   typedef struct packed {
      logic                vld;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// Pointer resets to NREQ-1 so requester 0 has first priority.
module rr_arbiter
   import mul_sched_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int ID_W = id_w(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_any,
   output logic [ID_W-1:0] ptr
);

   int              idx;
   logic [ID_W-1:0] idx_v;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      idx_v   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + 1 + i;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_v = ID_W'(idx);
         if (!gnt_any && req[idx_v]) begin
            gnt_any = 1'b1;
            gnt_id  = idx_v;
         end
      end
      // no grants may leak out while the block is held in reset
      if (!rst_n) begin
         gnt_any = 1'b0;
         gnt_id  = '0;
      end
      gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= ID_W'(NREQ - 1);
      else if (gnt_any) ptr <= gnt_id;
   end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one registered multiplier among NREQ requesters; a tag pipeline
// of depth LAT returns each product with the id of its requester.
module mul_rr_scheduler
   import mul_sched_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int NREQ = 4,
   parameter  int LAT  = MUL_LAT,
   localparam int ID_W = id_w(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [N-1:0]      mul_a,
   output logic [N-1:0]      mul_b,
   output logic              mul_en_a,
   output logic              mul_en_b,
   input  logic [2*N-1:0]    mul_p,
   output logic              resp_valid,
   output logic [ID_W-1:0]   resp_id,
   output logic [2*N-1:0]    resp_p,
   output logic              busy
);

   logic [ID_W-1:0] gnt_id;
   logic            gnt_any;
   logic [ID_W-1:0] arb_ptr;
   tag_t            tag_q [LAT];
   logic            unused_bits;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .gnt     (req_ready),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any),
      .ptr     (arb_ptr)
   );

   // operands are zeroed when idle; the multiplier holds its own registers
   always_comb begin
      mul_a    = '0;
      mul_b    = '0;
      mul_en_a = gnt_any;
      mul_en_b = gnt_any;
      if (gnt_any) begin
         mul_a = req_a[int'(gnt_id)*N +: N];
         mul_b = req_b[int'(gnt_id)*N +: N];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= '{vld: gnt_any, id: MAX_ID_W'(gnt_id)};
         for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   always_comb begin
      busy = gnt_any;
      for (int k = 0; k < LAT; k++) busy = busy | tag_q[k].vld;
   end

   assign resp_valid  = tag_q[LAT-1].vld;
   assign resp_id     = tag_q[LAT-1].id[ID_W-1:0];
   assign resp_p      = mul_p;
   assign unused_bits = ^{arb_ptr, tag_q[LAT-1].id};

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Shares one registered 8x8 adder-tree multiplier between NREQ requesters.
- Requesters present operand pairs with a valid/ready handshake. A round-robin arbiter grants one requester per cycle and drives the multiplier operand bus and load enables.
- A tag pipeline matched to the multiplier latency returns each product on a common response bus, tagged with the requester id.
- Sits between the requesting engines and the multiplier instance. The multiplier itself is not included.

Parameters:
- N, 8, operand width; product width is 2*N.
- NREQ, 4, number of requesters (2..16).
- LAT, 2, clock edges from operand-load edge to product-valid; fixed by the multiplier (operand registers, then product register).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant, one-hot or zero.
- req_a  in  NREQ*N  operand a, requester i in bits [i*N +: N].
- req_b  in  NREQ*N  operand b, same packing.
- mul_a  out  N  multiplier operand a.
- mul_b  out  N  multiplier operand b.
- mul_en_a  out  1  multiplier operand-a load enable.
- mul_en_b  out  1  multiplier operand-b load enable.
- mul_p  in  2*N  registered product from the multiplier.
- resp_valid  out  1  product valid this cycle.
- resp_id  out  $clog2(NREQ)  requester id of the product.
- resp_p  out  2*N  product (passthrough of mul_p).
- busy  out  1  any request in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Tag pipeline valid bits cleared; resp_valid=0, resp_id=0, busy=0.
  - Round-robin pointer set to NREQ-1, so requester 0 has first priority.
  - req_ready, mul_en_a and mul_en_b are forced to 0 while rst_n is low.
- Arbitration (combinational, per cycle):
  - Search starts at pointer+1 and wraps modulo NREQ.
  - The first requester with req_valid=1 wins; exactly one req_ready bit is set. All zero if no valid.
  - req_ready may depend on req_valid in the same cycle. Requesters must not make req_valid depend on req_ready.
- Issue:
  - On a grant to requester g: mul_a=req_a[g], mul_b=req_b[g], mul_en_a=mul_en_b=1, all in the same cycle.
  - With no grant: mul_en_a=mul_en_b=0 and mul_a/mul_b=0. The multiplier holds its operands.
  - Handshake completes at the edge where req_valid[g]&&req_ready[g]. At that edge the pointer updates to g; otherwise the pointer holds.
  - A requester holding req_valid high after a grant has re-issued a new request. Every granted cycle is a separate multiply.
- Tag pipeline:
  - LAT stages of {valid, id}. Stage 0 loads {grant_any, g} every edge; stage k loads stage k-1.
  - resp_valid and resp_id come from stage LAT-1 registered output. They coincide with mul_p for the operands loaded LAT edges earlier.
  - resp_p = mul_p unconditionally; it is meaningful only when resp_valid=1.
- Throughput and latency:
  - One issue per cycle sustained. A grant at edge k gives resp_valid high in the cycle after edge k+1.
  - There is no response backpressure; consumers must accept every response.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 cycles.
- busy = OR of all tag-stage valid bits, OR grant_any.
- Reset mid-operation: in-flight tags are dropped. No resp_valid is produced for them after rst_n releases, even though the multiplier's P register still holds stale data.
- Single requester valid: granted every cycle regardless of pointer position.
- Pointer wrap: after NREQ-1 the next search starts at 0.

Decomposition:
- Package mul_sched_pkg:
  - MUL_LAT=2.
  - Function id_w(nreq) = $clog2(nreq), minimum 1.
  - typedef tag_t = struct {logic vld; logic [ID_W-1:0] id}.
- One sub-module, rr_arbiter:
  - Parameters: NREQ.
  - Ports: clk, rst_n, req, gnt (one-hot), gnt_id, gnt_any, plus the pointer register.
  - The top level holds the operand mux and the tag pipeline.

Test Plan:
- Reset, then single issue: requester 2 issues a=8'd12, b=8'd11 at edge k. Required: req_ready=4'b0100 that cycle; resp_valid=1, resp_id=2, resp_p=16'd132 in the cycle after edge k+1; busy drops after.
- All four requesters continuously valid with a=i+1, b=8'd255 for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; responses 255, 510, 765, 1020 repeating; resp_valid held high 8 consecutive cycles.
- Back-to-back from requester 1 with pairs (255,255), (0,77), (1,1). Required: responses 65025, 0, 1 on consecutive cycles, all with id 1.
- Pointer fairness: requester 3 is granted, then requesters 0 and 3 both assert valid. Required: requester 0 is granted first, then 3.
- Reset mid-flight: issue (9,9) and (7,7) on consecutive cycles, then assert rst_n low asynchronously between edges. Required: resp_valid=0 immediately and stays 0 for 3 cycles after release; pointer resets so requester 0 wins the next contention.
- Idle gaps: requests only every third cycle. Required: mul_en_a/mul_en_b high only in granted cycles, and resp_valid never asserted in a cycle with no matching issue two edges earlier.
